parallel_in_serial_out_piso_tx: RTL and testbench
=================================================

# parallel_in_serial_out_piso_tx

Parameterised parallel-to-serial transmitter that produces the serial bit stream consumed by the team's serial-in shift registers. A producer hands over parallel words with a valid/ready handshake. The block shifts each word out one bit per clock and marks frame start and end. A one-word hold buffer lets consecutive words stream with no idle gap.

## Interface
- DATA_WIDTH, 8, bits per word, minimum 2
- MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 first, 0 = bit 0 first
- Clk_In  input  1  single clock, rising edge
- Reset_In  input  1  asynchronous, active-low reset
- Parallel_Data_In  input  DATA_WIDTH  word to transmit
- Load_Valid_In  input  1  producer has a word on Parallel_Data_In
- Load_Ready_Out  output  1  block can accept a word this cycle
- Serial_Data_Out  output  1  current serial bit, 0 when not valid
- Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit
- Frame_Start_Out  output  1  high with the first bit of each word
- Frame_Done_Out  output  1  high with the last bit of each word
- Busy_Out  output  1  high while in SHIFT

## Operation
- Registers:
  - shifter (DATA_WIDTH bits)
  - bit counter, 0..DATA_WIDTH-1, width $clog2(DATA_WIDTH)
  - hold buffer with hold_full flag
  - state register
- Handshake: a word is accepted on a rising edge where Load_Valid_In && Load_Ready_Out. The producer holds Parallel_Data_In and Load_Valid_In stable while valid && !ready.
- Load_Ready_Out = !hold_full, driven combinationally from a register.
- IDLE:
  - An accepted word loads straight into the shifter, counter <= 0, and the state goes to SHIFT.
  - The hold buffer is always empty in IDLE.
- SHIFT:
  - Each cycle presents one bit: shifter[DATA_WIDTH-1] if MSB_FIRST, else shifter[0].
  - The shifter shifts toward the output end and the counter increments.
  - Frame_Start_Out = (counter == 0). Frame_Done_Out = (counter == DATA_WIDTH-1).
- Accept while in SHIFT, not on the last bit: the word goes into the hold buffer, so hold_full = 1 and Load_Ready_Out = 0.
- Last-bit edge (counter == DATA_WIDTH-1), in priority order:
  1. hold_full: hold moves to the shifter, hold_full <= 0, counter <= 0, stay in SHIFT with no gap.
  2. Hold empty and a word is accepted on this edge: the word bypasses into the shifter, counter <= 0, stay in SHIFT.
  3. Otherwise: go to IDLE.
- Cases 1 and 2 cannot occur together, because Load_Ready_Out = 0 whenever hold_full = 1.
- Sustained throughput is one word per DATA_WIDTH cycles.
- Serial_Valid_Out = Busy_Out = (state == SHIFT).
- Frame_Start_Out, Frame_Done_Out and Serial_Data_Out are 0 whenever Serial_Valid_Out = 0.

## Timing
- Reset values, asserted asynchronously while Reset_In = 0:
  - state IDLE, shifter 0, counter 0, hold_full 0
  - Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out, Frame_Done_Out and Busy_Out all 0
  - Load_Ready_Out 1
- Latency: a word accepted at edge k in IDLE puts its first bit on Serial_Data_Out after edge k. Its last bit is presented after edge k+DATA_WIDTH-1.
- Back-to-back words: the first bit of word n+1 directly follows the last bit of word n. Serial_Valid_Out stays high throughout.
- Reset mid-frame: the frame is aborted and the hold buffer is discarded. No partial bits appear after reset release; transmission restarts only on a new accept.
- All outputs are registered or derived from registers. There is no combinational path from the inputs to any output.

## Structure
- Shared package piso_tx_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_tx_state_t
  - the DATA_WIDTH default localparam
- Single module; the counter, hold buffer and FSM are inline. No sub-module is warranted.

## Test plan
- Reset asserted mid-idle and released: all outputs 0 and Load_Ready_Out = 1; no output activity for 5 cycles with Load_Valid_In = 0.
- Single 0xA5 word, MSB_FIRST = 1:
  - bits 1,0,1,0,0,1,0,1 on the 8 cycles after the accept edge
  - Frame_Start_Out on bit 1, Frame_Done_Out on bit 8
  - returns to IDLE (Busy_Out = 0) the cycle after bit 8
- Back-to-back 0x3C then 0xC3 with Load_Valid_In held:
  - 16 contiguous valid bits 00111100 11000011
  - Load_Ready_Out low from the second accept until the hold moves to the shifter
- Backpressure: a third word 0xFF is held valid while Load_Ready_Out = 0. It is accepted only after the hold empties and is transmitted intact.
- Last-bit bypass: 0x80 accepted at the last-bit edge of 0x01 with the hold empty. Output is 00000001 10000000 with no gap.
- MSB_FIRST = 0 with 0x01: bits 1,0,0,0,0,0,0,0.
- Reset mid-frame (at bit 4 of 0xF0 with the hold full): outputs go to 0 immediately, no further bits appear, and Load_Ready_Out = 1 after release.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
package piso_tx_pkg;

  typedef enum logic {IDLE, SHIFT} piso_tx_state_t;

  localparam int PISO_TX_DATA_WIDTH = 8;

endpackage

// File: rtl/parallel_in_serial_out_piso_tx.sv
// Parallel-to-serial transmitter with a one-word hold buffer so that
// consecutive words stream out with no idle cycle between frames.
module parallel_in_serial_out_piso_tx
  import piso_tx_pkg::*;
#(
  parameter int DATA_WIDTH = PISO_TX_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic                  Busy_Out
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  piso_tx_state_t        state;
  logic [DATA_WIDTH-1:0] shifter;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [CNT_W-1:0]      bit_cnt;

  logic accept;
  logic last_bit;
  logic out_bit;
  logic busy;

  assign accept   = Load_Valid_In && !hold_full;
  assign last_bit = (bit_cnt == LAST_BIT);
  assign out_bit  = MSB_FIRST ? shifter[DATA_WIDTH-1] : shifter[0];
  assign busy     = (state == SHIFT);

  // Every output is a function of registers only; the input handshake never
  // reaches an output combinationally.
  assign Load_Ready_Out   = !hold_full;
  assign Busy_Out         = busy;
  assign Serial_Valid_Out = busy;
  assign Serial_Data_Out  = busy && out_bit;
  assign Frame_Start_Out  = busy && (bit_cnt == '0);
  assign Frame_Done_Out   = busy && last_bit;

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state     <= IDLE;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shifter <= Parallel_Data_In;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            // Refill priority: held word first, then a word arriving now.
            if (hold_full) begin
              shifter   <= hold;
              hold_full <= 1'b0;
              bit_cnt   <= '0;
            end else if (accept) begin
              shifter <= Parallel_Data_In;
              bit_cnt <= '0;
            end else begin
              state   <= IDLE;
              bit_cnt <= '0;
            end
          end else begin
            if (MSB_FIRST)
              shifter <= {shifter[DATA_WIDTH-2:0], 1'b0};
            else
              shifter <= {1'b0, shifter[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (accept) begin
              hold      <= Parallel_Data_In;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx.sv
// Scoreboard bench: stimulus pushes hand-written bit sequences, per-instance
// monitors pop and compare on every presented serial bit.
module tb_parallel_in_serial_out_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       ready_m, sdat_m, sval_m, start_m, done_m, busy_m;
  logic       ready_l, sdat_l, sval_l, start_l, done_l, busy_l;

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .Clk_In(clk), .Reset_In(rst_n), .Parallel_Data_In(data_m),
    .Load_Valid_In(valid_m), .Load_Ready_Out(ready_m),
    .Serial_Data_Out(sdat_m), .Serial_Valid_Out(sval_m),
    .Frame_Start_Out(start_m), .Frame_Done_Out(done_m), .Busy_Out(busy_m));

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .Clk_In(clk), .Reset_In(rst_n), .Parallel_Data_In(data_l),
    .Load_Valid_In(valid_l), .Load_Ready_Out(ready_l),
    .Serial_Data_Out(sdat_l), .Serial_Valid_Out(sval_l),
    .Frame_Start_Out(start_l), .Frame_Done_Out(done_l), .Busy_Out(busy_l));

  // b: bit, s: frame start, d: frame done, c: must directly follow a valid bit
  typedef struct packed {logic b; logic s; logic d; logic c;} exp_t;
  exp_t q_m[$];
  exp_t q_l[$];
  bit   prev_m = 1'b0;
  bit   prev_l = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // pattern is the transmit order written MSB-side first: pattern[7] leaves first
  task automatic push_word(input int which, input logic [7:0] pattern, input logic contig);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b = pattern[i];
      e.s = (i == 7);
      e.d = (i == 0);
      e.c = (i == 7) ? contig : 1'b1;
      if (which == 0) q_m.push_back(e); else q_l.push_back(e);
    end
  endtask

  task automatic mon(input int which, input logic v, input logic d, input logic s,
                     input logic dn, input logic bz);
    exp_t  e;
    bit    empty;
    bit    prev;
    string tag;
    tag  = (which == 0) ? "msb" : "lsb";
    prev = (which == 0) ? prev_m : prev_l;
    chk({tag, "_busy_eq_valid"}, 32'(bz), 32'(v));
    if (!v) begin
      chk({tag, "_idle_outputs_zero"}, 32'({d, s, dn}), 32'd0);
    end else begin
      empty = 1'b0;
      if (which == 0) begin
        if (q_m.size() == 0) empty = 1'b1; else e = q_m.pop_front();
      end else begin
        if (q_l.size() == 0) empty = 1'b1; else e = q_l.pop_front();
      end
      if (empty) begin
        chk({tag, "_unexpected_valid_bit"}, 32'(v), 32'd0);
      end else begin
        chk({tag, "_serial_bit"}, 32'(d), 32'(e.b));
        chk({tag, "_frame_start"}, 32'(s), 32'(e.s));
        chk({tag, "_frame_done"}, 32'(dn), 32'(e.d));
        if (e.c) chk({tag, "_no_gap"}, 32'(prev), 32'd1);
      end
    end
    if (which == 0) prev_m = v; else prev_l = v;
  endtask

  always @(negedge clk) mon(0, sval_m, sdat_m, start_m, done_m, busy_m);
  always @(negedge clk) mon(1, sval_l, sdat_l, start_l, done_l, busy_l);

  // Offers a word and returns once accepted; waited = cycles ready was low.
  task automatic send(input int which, input logic [7:0] word, input logic [7:0] pattern,
                      input logic contig, output int waited);
    bit r;
    bit ok;
    ok = 1'b0;
    waited = 0;
    if (which == 0) begin data_m = word; valid_m = 1'b1; end
    else begin data_l = word; valid_l = 1'b1; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      r = (which == 0) ? ready_m : ready_l;
      @(posedge clk);
      if (r) begin ok = 1'b1; break; end
      waited++;
    end
    if (ok) push_word(which, pattern, contig);
    else chk("accept_timeout", 32'd0, 32'd1);
    #1;
    if (which == 0) valid_m = 1'b0; else valid_l = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q_m.size() == 0 && q_l.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_msb_queue", 32'(q_m.size()), 32'd0);
    chk("drain_lsb_queue", 32'(q_l.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int w;

  initial begin
    rst_n = 1'b0; valid_m = 1'b0; valid_l = 1'b0; data_m = '0; data_l = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_ready", 32'(ready_m), 32'd1);
    chk("reset_outputs", 32'({sdat_m, sval_m, start_m, done_m, busy_m}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ready", 32'(ready_m), 32'd1);

    send(0, 8'hA5, 8'b10100101, 1'b0, w);
    @(negedge clk);
    chk("a5_first_bit_latency", 32'({sval_m, start_m, sdat_m}), 32'b111);
    drain();

    send(0, 8'h3C, 8'b00111100, 1'b0, w);
    send(0, 8'hC3, 8'b11000011, 1'b1, w);
    @(negedge clk);
    chk("ready_low_with_hold_full", 32'(ready_m), 32'd0);
    send(0, 8'hFF, 8'b11111111, 1'b1, w);
    chk("ff_backpressure_cycles", 32'(w), 32'd6);
    drain();

    send(0, 8'h01, 8'b00000001, 1'b0, w);
    repeat (7) @(posedge clk);
    #1;
    send(0, 8'h80, 8'b10000000, 1'b1, w);
    chk("bypass_no_wait", 32'(w), 32'd0);
    drain();

    send(1, 8'h01, 8'b10000000, 1'b0, w);
    drain();

    send(0, 8'hF0, 8'b11110000, 1'b0, w);
    send(0, 8'h55, 8'b01010101, 1'b1, w);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q_m.delete();
    q_l.delete();
    #1;
    chk("midframe_reset_outputs", 32'({sdat_m, sval_m, start_m, done_m, busy_m}), 32'd0);
    chk("midframe_reset_ready", 32'(ready_m), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(ready_m), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("post_reset_quiet", 32'({sval_m, busy_m}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
